// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle CPU: sequences the shared datapath through
// fetch/decode/execute/memory/write-back, stalls on memory and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count,
  output logic [3:0]         state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JAL    = 4'd11,
    S_ADDIEX = 4'd12,
    S_ADDIWB = 4'd13
  } state_e;

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 started_q;
  logic                 retire;

  // started_q holds IDLE for one extra cycle after reset release, so the
  // first FETCH lands on the second rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    illegal_op = 1'b0;
    case (state_q)
      S_IDLE: if (started_q) state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_en     = 1'b1;
          alu_src_b = 2'b01;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_R:           state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          OP_ADDI:        state_d = S_ADDIEX;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 2'b01;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_en     = (opcode == OP_BNE) ? ~zero : zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_en     = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        pc_en      = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    count_d = retire ? count_q + COUNT_W'(1) : count_q;
  end

  assign instr_count = count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: each instruction is expanded into
// its expected cycle-by-cycle state path and compared against a per-state output table.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, illegal_op;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic [31:0] instr_count;
  logic [3:0]  state;
  logic [18:0] ctrl;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_count = '0;
  logic [5:0]  legal_ops [8];

  typedef struct {
    int unsigned st;
    bit          mr;
  } cyc_t;

  multicycle_ctrl #(.COUNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    for (int i = 0; i < 8; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected control word for a cycle, straight from the per-state output list.
  function automatic logic [18:0] exp_ctrl(input int unsigned st, input bit mr, input bit z,
                                           input logic [5:0] op);
    bit pe = 0, io = 0, mrd = 0, mwr = 0, irw = 0, rw = 0, asa = 0, ill = 0;
    bit [1:0] rd = 0, m2r = 0, asb = 0, aop = 0, ps = 0;
    case (st)
      1:  begin mrd = 1; if (mr) begin irw = 1; pe = 1; asb = 2'b01; end end
      2:  begin asb = 2'b11; ill = !is_legal(op); end
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin io = 1; mrd = 1; end
      5:  begin m2r = 2'b01; rw = 1; end
      6:  begin io = 1; mwr = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rd = 2'b01; rw = 1; end
      9:  begin asa = 1; aop = 2'b01; ps = 2'b01; pe = (op == OP_BNE) ? !z : z; end
      10: begin pe = 1; ps = 2'b10; end
      11: begin pe = 1; ps = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
      12: begin asa = 1; asb = 2'b10; end
      13: begin rw = 1; end
      default: ;
    endcase
    return {pe, io, mrd, mwr, irw, rd, m2r, rw, asa, asb, aop, ps, ill};
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, " state"}, 64'(state), 64'd0);
    check_val({tag, " ctrl"}, 64'(ctrl), 64'd0);
    check_val({tag, " count"}, 64'(instr_count), 64'(exp_count));
  endtask

  // One IDLE cycle follows reset release before FETCH.
  task automatic post_reset_idle();
    @(negedge clk);
    mem_ready = 1'($urandom);
    #1;
    check_idle("post_reset");
  endtask

  // wf/wm: wait cycles in FETCH and in the memory state; zbr<0 means random zero in BRANCH.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int zbr,
                           input bit abort_exec);
    cyc_t path[$];
    for (int i = 0; i < wf; i++) path.push_back('{1, 1'b0});
    path.push_back('{1, 1'b1});
    path.push_back('{2, 1'($urandom)});
    case (op)
      OP_LW: begin
        path.push_back('{3, 1'($urandom)});
        for (int i = 0; i < wm; i++) path.push_back('{4, 1'b0});
        path.push_back('{4, 1'b1});
        path.push_back('{5, 1'($urandom)});
      end
      OP_SW: begin
        path.push_back('{3, 1'($urandom)});
        for (int i = 0; i < wm; i++) path.push_back('{6, 1'b0});
        path.push_back('{6, 1'b1});
      end
      OP_R:           begin path.push_back('{7, 1'($urandom)}); path.push_back('{8, 1'($urandom)}); end
      OP_BEQ, OP_BNE: path.push_back('{9, 1'($urandom)});
      OP_J:           path.push_back('{10, 1'($urandom)});
      OP_JAL:         path.push_back('{11, 1'($urandom)});
      OP_ADDI:        begin path.push_back('{12, 1'($urandom)}); path.push_back('{13, 1'($urandom)}); end
      default: ;
    endcase
    foreach (path[i]) begin
      @(negedge clk);
      mem_ready = path[i].mr;
      zero      = (path[i].st == 9 && zbr >= 0) ? zbr[0] : 1'($urandom);
      opcode    = (path[i].st == 1) ? 6'($urandom) : op;
      #1;
      check_val($sformatf("state op%0h cyc%0d", op, i), 64'(state), 64'(path[i].st));
      check_val($sformatf("ctrl op%0h st%0d", op, path[i].st), 64'(ctrl),
                64'(exp_ctrl(path[i].st, mem_ready, zero, opcode)));
      check_val($sformatf("count op%0h cyc%0d", op, i), 64'(instr_count), 64'(exp_count));
      if (abort_exec && path[i].st == 7) begin
        #1 rst_n = 1'b0;
        exp_count = '0;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        #1;
        check_idle("reset_held");
        rst_n = 1'b1;
        post_reset_idle();
        return;
      end
    end
    if (is_legal(op)) exp_count++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI};
    @(negedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    post_reset_idle();

    run_instr(OP_LW,   0, 0, -1, 1'b0);
    run_instr(OP_SW,   0, 3, -1, 1'b0);
    run_instr(OP_BEQ,  0, 0,  1, 1'b0);
    run_instr(OP_BEQ,  0, 0,  0, 1'b0);
    run_instr(OP_BNE,  0, 0,  0, 1'b0);
    run_instr(OP_JAL,  0, 0, -1, 1'b0);
    run_instr(6'h3F,   0, 0, -1, 1'b0);
    run_instr(OP_ADDI, 2, 0, -1, 1'b0);
    run_instr(OP_R,    1, 0, -1, 1'b1);
    run_instr(OP_J,    0, 0, -1, 1'b0);

    for (int n = 0; n < 120; n++) begin
      int unsigned k = $urandom_range(0, 9);
      logic [5:0]  op = (k < 8) ? legal_ops[k] : 6'($urandom);
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, 1'b0);
    end

    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check_val("final state", 64'(state), 64'd1);
    check_val("final count", 64'(instr_count), 64'(exp_count));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
